axi4l_burst_writer: RTL and testbench
=====================================

Name: axi4l_burst_writer

Overview:
- AXI4-Lite write initiator; the transmit end of the burst link whose transferred beats are counted on the far side.
- On a start pulse, fetches BEATS data words from an upstream valid/ready stream.
- Issues each word as one AXI4-Lite write to incrementing addresses, waits for each write response, then pulses done.
- Sits between the local data source and the AXI4-Lite interconnect.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- BEATS, 16, writes per burst; must be ≥2; beat counter width $clog2(BEATS).

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle burst request
- i_base_addr  in  ADDR_WIDTH  first write address, sampled with i_start
- i_data  in  DATA_WIDTH  upstream write data
- i_data_valid  in  1  upstream data valid
- o_data_ready  out  1  upstream data ready
- o_awaddr  out  ADDR_WIDTH  AXI write address
- o_awvalid  out  1  AXI address valid
- i_awready  in  1  AXI address ready
- o_wdata  out  DATA_WIDTH  AXI write data
- o_wstrb  out  DATA_WIDTH/8  AXI byte strobes, all ones
- o_wvalid  out  1  AXI data valid
- i_wready  in  1  AXI data ready
- i_bresp  in  2  AXI write response
- i_bvalid  in  1  AXI response valid
- o_bready  out  1  AXI response ready
- o_busy  out  1  burst in progress
- o_done  out  1  one-cycle pulse on burst completion
- o_error  out  1  sticky: some beat of the last burst returned a non-OKAY response

Behaviour:
- Reset (arstn=0, async): state IDLE, counters 0. All outputs 0 except o_wstrb (all ones).
- FSM states IDLE, FETCH, SEND, RESP.
- IDLE:
  - i_start=1 → latch i_base_addr into the address register, clear beat count and o_error, go to FETCH.
  - i_start is ignored in every other state.
- FETCH:
  - o_data_ready=1.
  - On i_data_valid: latch i_data into the wdata register, go to SEND.
  - Minimum 1 cycle per beat.
- SEND:
  - Assert o_awvalid and o_wvalid together.
  - Each channel drops independently in the cycle after its own handshake (valid&ready).
  - Neither valid is withdrawn before its handshake; awaddr and wdata are stable while valid.
  - When both handshakes are complete (same cycle or different cycles) → RESP.
- RESP:
  - o_bready=1. On i_bvalid:
  - i_bresp≠2'b00 → set o_error.
  - Beat count == BEATS-1 → IDLE and o_done=1 for exactly one cycle (registered, first cycle back in IDLE).
  - Otherwise: count+1, address + DATA_WIDTH/8, → FETCH.
- Address arithmetic is modulo 2^ADDR_WIDTH; wrap past the top is silent.
- o_busy=1 in FETCH, SEND and RESP.
- i_start in the same cycle o_done is high: accepted (state is IDLE).
- i_bvalid outside RESP: ignored; o_bready=0.
- Latency, zero-wait slave, full burst: 1 start + BEATS×(1 FETCH + 1 SEND + 1 RESP) cycles; o_done in the following cycle.

Optional Feature:
- Macro AXI4L_ABORT_ON_ERROR_EN.
- Defined: a non-OKAY bresp in RESP ends the burst immediately: → IDLE, o_done pulses, o_error=1, remaining beats are not fetched.
- Undefined: the burst always completes all BEATS writes; o_error only records the failure.

Decomposition:
- Package axi4l_pkg holds:
  - resp_t enum: OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - wr_state_t enum for the FSM.
  - Localparam STRB_ALL.
- Sub-module beat_counter holds the beat counter with clear/increment and last-beat flag, parameterised by BEATS.

Test Plan:
- Zero-wait slave, base 32'h0000_1000, data 1..16 → 16 writes at 0x1000, 0x1004 … 0x103C with matching data; o_done one cycle after 16th bresp; o_error=0.
- awready 3 cycles before wready on beat 0 → awvalid drops after its handshake, wvalid is held with stable wdata until wready, a single RESP follows; the reverse ordering (wready first) behaves the same way.
- i_data_valid stalled 5 cycles on beat 7 → FSM holds FETCH with o_data_ready=1 and no AXI valids; burst then completes normally.
- bresp=SLVERR on beat 4:
  - Macro undefined → 16 writes, o_error=1.
  - Macro defined → done after beat 4, exactly 5 writes, o_error=1.
- arstn low mid-SEND on beat 9 → all valids and o_busy drop immediately; after release a new i_start (base 0x2000) runs a full clean burst.
- Base 32'hFFFF_FFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 …; i_start pulsed mid-burst is ignored; i_start on the o_done cycle starts the next burst.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared types and constants for the AXI4-Lite burst write initiator.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    SEND  = 2'b10,
    RESP  = 2'b11
  } wr_state_t;

  // Wide enough for a 64-bit data bus; narrower buses take the low bits.
  localparam logic [7:0] STRB_ALL = 8'hFF;

  function automatic logic resp_is_error(input resp_t resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/axi4l_burst_writer_beat_counter.sv
// Beat counter for the burst writer: clear, increment and last-beat flag.
module beat_counter #(
  parameter int BEATS = 16,
  localparam int CW   = $clog2(BEATS)
) (
  input  logic clk,
  input  logic arstn,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count_r;

  // Beat index register; clear wins over increment.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == CW'(BEATS - 1));

endmodule

// File: rtl/axi4l_burst_writer.sv
// AXI4-Lite burst write initiator: fetches BEATS words and writes them to incrementing addresses.
// Optional macro AXI4L_ABORT_ON_ERROR_EN ends the burst on the first non-OKAY response.
module axi4l_burst_writer
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS      = 16
) (
  input  logic                    clk,
  input  logic                    arstn,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [ADDR_WIDTH-1:0]   o_awaddr,
  output logic                    o_awvalid,
  input  logic                    i_awready,
  output logic [DATA_WIDTH-1:0]   o_wdata,
  output logic [DATA_WIDTH/8-1:0] o_wstrb,
  output logic                    o_wvalid,
  input  logic                    i_wready,
  input  logic [1:0]              i_bresp,
  input  logic                    i_bvalid,
  output logic                    o_bready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int                    STRB_W    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRB_W);

  wr_state_t             state_r;
  wr_state_t             state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  aw_pend_r;
  logic                  w_pend_r;
  logic                  error_r;
  logic                  done_r;

  logic start_s;
  logic data_hs_s;
  logic aw_hs_s;
  logic w_hs_s;
  logic send_done_s;
  logic b_hs_s;
  logic bresp_err_s;
  logic finish_s;
  logic beat_inc_s;
  logic last_beat_s;

  assign start_s     = (state_r == IDLE) && i_start;
  assign data_hs_s   = (state_r == FETCH) && i_data_valid;
  assign aw_hs_s     = aw_pend_r && i_awready;
  assign w_hs_s      = w_pend_r && i_wready;
  // Each channel is done once its own handshake has happened, now or earlier.
  assign send_done_s = (state_r == SEND) && (!aw_pend_r || i_awready) && (!w_pend_r || i_wready);
  assign b_hs_s      = (state_r == RESP) && i_bvalid;
  assign bresp_err_s = resp_is_error(resp_t'(i_bresp));
`ifdef AXI4L_ABORT_ON_ERROR_EN
  assign finish_s    = b_hs_s && (last_beat_s || bresp_err_s);
`else
  assign finish_s    = b_hs_s && last_beat_s;
`endif
  assign beat_inc_s  = b_hs_s && !finish_s;

  beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk   (clk),
    .arstn (arstn),
    .clr   (start_s),
    .inc   (beat_inc_s),
    .last  (last_beat_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (i_start) state_s = FETCH; else state_s = IDLE;
      FETCH:   if (i_data_valid) state_s = SEND; else state_s = FETCH;
      SEND:    if (send_done_s) state_s = RESP; else state_s = SEND;
      RESP: begin
        if (finish_s) begin
          state_s = IDLE;
        end else if (b_hs_s) begin
          state_s = FETCH;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: write address, write data and per-channel valid flags.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_r    <= '0;
      wdata_r   <= '0;
      aw_pend_r <= 1'b0;
      w_pend_r  <= 1'b0;
    end else begin
      if (start_s) begin
        addr_r <= i_base_addr;
      end else if (beat_inc_s) begin
        addr_r <= addr_r + ADDR_STEP;
      end else begin
        addr_r <= addr_r;
      end
      if (data_hs_s) begin
        wdata_r <= i_data;
      end else begin
        wdata_r <= wdata_r;
      end
      if (data_hs_s) begin
        aw_pend_r <= 1'b1;
        w_pend_r  <= 1'b1;
      end else begin
        aw_pend_r <= aw_pend_r && !aw_hs_s;
        w_pend_r  <= w_pend_r && !w_hs_s;
      end
    end
  end

  // Sticky error flag and completion pulse.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      error_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      if (start_s) begin
        error_r <= 1'b0;
      end else if (b_hs_s && bresp_err_s) begin
        error_r <= 1'b1;
      end else begin
        error_r <= error_r;
      end
      done_r <= finish_s;
    end
  end

  assign o_data_ready = (state_r == FETCH);
  assign o_awaddr     = addr_r;
  assign o_awvalid    = aw_pend_r;
  assign o_wdata      = wdata_r;
  assign o_wstrb      = STRB_ALL[STRB_W-1:0];
  assign o_wvalid     = w_pend_r;
  assign o_bready     = (state_r == RESP);
  assign o_busy       = (state_r != IDLE);
  assign o_done       = done_r;
  assign o_error      = error_r;

endmodule

// File: tb/tb_axi4l_burst_writer.sv
// Directed, scoreboard-based bench for axi4l_burst_writer with a behavioural source and AXI slave.
module tb_axi4l_burst_writer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BEATS = 16;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [DW-1:0] i_data;
  logic          i_data_valid;
  logic          o_data_ready;
  logic [AW-1:0] o_awaddr;
  logic          o_awvalid;
  logic          i_awready;
  logic [DW-1:0] o_wdata;
  logic [DW/8-1:0] o_wstrb;
  logic          o_wvalid;
  logic          i_wready;
  logic [1:0]    i_bresp;
  logic          i_bvalid;
  logic          o_bready;
  logic          o_busy;
  logic          o_done;
  logic          o_error;

  always #5 clk = ~clk;

  axi4l_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
    .clk(clk), .arstn(arstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
    .o_awaddr(o_awaddr), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;

  logic [AW-1:0] exp_base;
  logic [DW-1:0] data_base;
  int src_idx, stall_beat, stall_rem;
  int lat_beat, aw_lat, w_lat, err_beat;
  int aw_wait, w_wait;
  bit aw_hold, w_hold, stray_b, chain_req;
  logic [AW-1:0] aw_last, chain_base;
  logic [DW-1:0] w_last;
  int n_aw, n_w, n_b, n_writes, done_seen, done_cycle, last_b_cycle;
  logic [AW-1:0]    awq[$];
  logic [DW-1:0]    wq[$];
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_burst(input logic [AW-1:0] base, input logic [DW-1:0] dbase);
    exp_base = base;  data_base = dbase;
    src_idx = 0;  stall_beat = -1;  stall_rem = 0;
    lat_beat = -1;  aw_lat = 0;  w_lat = 0;  err_beat = -1;
    aw_wait = 0;  w_wait = 0;  aw_hold = 1'b0;  w_hold = 1'b0;
    n_aw = 0;  n_w = 0;  n_b = 0;  n_writes = 0;
    done_seen = 0;  done_cycle = -1;  last_b_cycle = -100;
    awq.delete();  wq.delete();  exp_q.delete();
  endtask

  // One clock: drive source/slave at the falling edge and score what the DUT shows.
  task automatic tick(input bit start, input logic [AW-1:0] base);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW+DW-1:0] e;
    int mn;
    @(negedge clk);
    cyc++;
    i_start = start;
    i_base_addr = base;
    if (o_done) begin
      done_seen++;
      done_cycle = cyc;
      check("done_not_busy", 64'(o_busy), 64'(0));
      if (chain_req) begin
        chain_req = 1'b0;
        i_start = 1'b1;
        i_base_addr = chain_base;
      end
    end
    // upstream source
    if (src_idx >= BEATS) begin
      i_data_valid = 1'b0;
    end else if (stall_rem > 0 && src_idx == stall_beat && o_data_ready) begin
      i_data_valid = 1'b0;
      stall_rem--;
      check("stall_awvalid", 64'(o_awvalid), 64'(0));
      check("stall_wvalid", 64'(o_wvalid), 64'(0));
      check("stall_busy", 64'(o_busy), 64'(1));
    end else begin
      i_data_valid = 1'b1;
      i_data = data_base + DW'(src_idx);
      if (o_data_ready) begin
        exp_q.push_back({exp_base + AW'(4 * src_idx), i_data});
        src_idx++;
      end
    end
    // AW channel
    if (aw_hold) begin
      check("aw_held", 64'(o_awvalid), 64'(1));
      check("awaddr_stable", 64'(o_awaddr), 64'(aw_last));
    end
    if (o_awvalid) begin
      check("aw_single", 64'(n_aw), 64'(n_b));
      i_awready = (aw_wait >= ((n_aw == lat_beat) ? aw_lat : 0));
      if (i_awready) begin
        awq.push_back(o_awaddr);  n_aw++;  aw_wait = 0;  aw_hold = 1'b0;
      end else begin
        aw_wait++;  aw_hold = 1'b1;  aw_last = o_awaddr;
      end
    end else begin
      i_awready = 1'b0;  aw_hold = 1'b0;
    end
    // W channel
    if (w_hold) begin
      check("w_held", 64'(o_wvalid), 64'(1));
      check("wdata_stable", 64'(o_wdata), 64'(w_last));
    end
    if (o_wvalid) begin
      check("w_single", 64'(n_w), 64'(n_b));
      check("wstrb", 64'(o_wstrb), 64'(4'hF));
      i_wready = (w_wait >= ((n_w == lat_beat) ? w_lat : 0));
      if (i_wready) begin
        wq.push_back(o_wdata);  n_w++;  w_wait = 0;  w_hold = 1'b0;
      end else begin
        w_wait++;  w_hold = 1'b1;  w_last = o_wdata;
      end
    end else begin
      i_wready = 1'b0;  w_hold = 1'b0;
    end
    // scoreboard
    while (awq.size() > 0 && wq.size() > 0) begin
      a = awq.pop_front();
      d = wq.pop_front();
      n_writes++;
      check("write_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("awaddr", 64'(a), 64'(e[AW+DW-1:DW]));
        check("wdata", 64'(d), 64'(e[DW-1:0]));
      end
    end
    // B channel
    mn = (n_aw < n_w) ? n_aw : n_w;
    if (mn > n_b) begin
      i_bvalid = 1'b1;
      i_bresp = (n_b == err_beat) ? 2'b10 : 2'b00;
      if (o_bready) begin
        n_b++;
        last_b_cycle = cyc;
      end
    end else begin
      i_bvalid = stray_b;
      i_bresp = 2'b00;
      if (stray_b) begin
        check("stray_bready", 64'(o_bready), 64'(0));
        check("stray_busy", 64'(o_busy), 64'(0));
      end
    end
  endtask

  task automatic start(input logic [AW-1:0] base);
    tick(1'b1, base);
    start_cyc = cyc;
  endtask

  task automatic finish_burst(input int exp_writes, input bit exp_err, input int exp_lat, input int mid_at);
    for (int i = 0; i < 600 && done_seen == 0; i++) begin
      tick(i == mid_at, 32'h5555_0000);
    end
    check("done_seen", 64'(done_seen), 64'(1));
    check("n_writes", 64'(n_writes), 64'(exp_writes));
    check("error", 64'(o_error), 64'(exp_err));
    check("exp_drained", 64'(exp_q.size()), 64'(0));
    check("done_after_b", 64'(done_cycle), 64'(last_b_cycle + 1));
    if (exp_lat > 0) check("latency", 64'(done_cycle - start_cyc), 64'(exp_lat));
  endtask

  task automatic idle_inputs();
    i_start = 1'b0;  i_base_addr = '0;  i_data = '0;  i_data_valid = 1'b0;
    i_awready = 1'b0;  i_wready = 1'b0;  i_bresp = 2'b00;  i_bvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, 64'(o_awvalid), 64'(0));
    check({tag, "_wvalid"}, 64'(o_wvalid), 64'(0));
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_data_ready"}, 64'(o_data_ready), 64'(0));
    check({tag, "_bready"}, 64'(o_bready), 64'(0));
    check({tag, "_done"}, 64'(o_done), 64'(0));
    check({tag, "_error"}, 64'(o_error), 64'(0));
    check({tag, "_wstrb"}, 64'(o_wstrb), 64'(4'hF));
  endtask

  initial begin
    int exp_w, exp_l;
    arstn = 1'b0;  stray_b = 1'b0;  chain_req = 1'b0;
    idle_inputs();
    new_burst('0, '0);
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    check("reset_awaddr", 64'(o_awaddr), 64'(0));
    check("reset_wdata", 64'(o_wdata), 64'(0));
    arstn = 1'b1;

    // zero-wait burst, data 1..16
    new_burst(32'h0000_1000, 32'd1);
    start(32'h0000_1000);
    finish_burst(16, 1'b0, 1 + 3 * BEATS, -1);
    tick(1'b0, '0);
    check("done_pulse_width", 64'(done_seen), 64'(1));

    // SLVERR on beat 4
`ifdef AXI4L_ABORT_ON_ERROR_EN
    exp_w = 5;  exp_l = 1 + 3 * 5;
`else
    exp_w = 16; exp_l = 1 + 3 * BEATS;
`endif
    new_burst(32'h0000_1800, 32'h1111_0000);
    err_beat = 4;
    start(32'h0000_1800);
    finish_burst(exp_w, 1'b1, exp_l, -1);

    // awready 3 cycles before wready on beat 0; o_error cleared by new start
    new_burst(32'h0000_0100, 32'hA000_0000);
    lat_beat = 0;  aw_lat = 0;  w_lat = 3;
    start(32'h0000_0100);
    tick(1'b0, '0);
    check("error_cleared", 64'(o_error), 64'(0));
    finish_burst(16, 1'b0, 1 + 3 * BEATS + 3, -1);

    // wready 3 cycles before awready on beat 0
    new_burst(32'h0000_0200, 32'hB000_0000);
    lat_beat = 0;  aw_lat = 3;  w_lat = 0;
    start(32'h0000_0200);
    finish_burst(16, 1'b0, 1 + 3 * BEATS + 3, -1);

    // upstream stall of 5 cycles on beat 7
    new_burst(32'h0000_0300, 32'hC000_0000);
    stall_beat = 7;  stall_rem = 5;
    start(32'h0000_0300);
    finish_burst(16, 1'b0, 1 + 3 * BEATS + 5, -1);
    check("stall_consumed", 64'(stall_rem), 64'(0));

    // address wrap, ignored mid-burst start, start on the done cycle
    new_burst(32'hFFFF_FFF8, 32'hD000_0000);
    chain_req = 1'b1;  chain_base = 32'h0000_4000;
    start(32'hFFFF_FFF8);
    finish_burst(16, 1'b0, 1 + 3 * BEATS, 10);
    check("chain_started", 64'(chain_req), 64'(0));
    new_burst(32'h0000_4000, 32'hE000_0000);
    start_cyc = cyc;
    finish_burst(16, 1'b0, 1 + 3 * BEATS, -1);

    // reset asserted mid-SEND on beat 9
    new_burst(32'h0000_3000, 32'hF000_0000);
    start(32'h0000_3000);
    for (int i = 0; i < 400; i++) begin
      tick(1'b0, '0);
      if (o_awvalid && n_b == 9) break;
    end
    check("reached_send9", 64'(n_b), 64'(9));
    arstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle_inputs();
    new_burst('0, '0);
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;
    new_burst(32'h0000_2000, 32'h0000_0100);
    start(32'h0000_2000);
    finish_burst(16, 1'b0, 1 + 3 * BEATS, -1);

    // bvalid while idle is ignored
    new_burst(32'h0000_5000, 32'h0);
    src_idx = BEATS;
    stray_b = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, '0);
    stray_b = 1'b0;
    tick(1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
